udp_led_sink: RTL

Consumes the UDP payload AXI-Stream from the Ethernet UDP stack in the `clk_eth` domain and drives the 8-bit `led` status bus. It buffers the first bytes of each frame in a shadow register and commits byte 0 to `led` only after a clean, complete frame. Errored or oversize frames are dropped and counted. It sits directly downstream of the UDP stack's payload output, and its `led` output feeds the SoC-side `led` status bus.

---
 rtl/udp_led_sink.sv | 109 ++++++++++
 1 files changed

// File: rtl/udp_led_sink.sv
// UDP payload sink: latches payload byte 0 onto led after a clean frame; counts good/dropped frames.
// Latency: led/frame_cnt/frame_pulse/drop_cnt update on the edge accepting tlast (visible next cycle).
// Backpressure: none; tready is a flop that is low only in reset and the first cycle after it.
module udp_led_sink #(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [7:0]       led,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             frame_pulse
);

    localparam int BW = $clog2(MAX_BYTES + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [7:0]    sh0, sh0_nxt;
    logic          accept;
    logic          commit;
    logic          drop;

    assign accept = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        sh0_nxt   = sh0;
        commit    = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    sh0_nxt  = s_axis_tdata;
                    bcnt_nxt = BW'(1);
                    if (s_axis_tlast) begin
                        commit = !s_axis_tuser;
                        drop   = s_axis_tuser;
                    end else begin
                        state_nxt = RECV;
                    end
                end
            end
            RECV: begin
                if (accept) begin
                    // Already holding MAX_BYTES: this beat makes the frame oversize.
                    if (bcnt >= BMAX) begin
                        if (s_axis_tlast) begin
                            drop      = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DROP;
                        end
                    end else begin
                        bcnt_nxt = bcnt + BW'(1);
                        if (s_axis_tlast) begin
                            commit    = !s_axis_tuser;
                            drop      = s_axis_tuser;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            DROP: begin
                if (accept && s_axis_tlast) begin
                    drop      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bcnt          <= '0;
            sh0           <= '0;
            s_axis_tready <= 1'b0;
            led           <= '0;
            frame_cnt     <= '0;
            drop_cnt      <= '0;
            frame_pulse   <= 1'b0;
        end else begin
            state         <= state_nxt;
            bcnt          <= bcnt_nxt;
            sh0           <= sh0_nxt;
            s_axis_tready <= 1'b1;
            frame_pulse   <= commit;
            // sh0_nxt covers the single-beat case where byte 0 arrives with tlast.
            if (commit) begin
                led <= sh0_nxt;
                if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule
